iob_fp_f2i: RTL and testbench
=============================

// Module: iob_fp_f2i
// PURPOSE
// - Pipelined IEEE-754 float -> signed two's-complement integer converter.
// - Unpacks the FP result format produced by the FP arithmetic units (adder etc.)
//   into integer form for address/index/quantisation paths in the datapath.
// - Fixed latency of 3 cycles; accepts one operand per cycle; start/done pulse protocol.
// PARAMETERS
// - DATA_W  32  float width (sign + exponent + fraction)
// - EXP_W   8   exponent width; BIAS = 2**(EXP_W-1)-1; MAN_W = DATA_W-EXP_W (includes hidden bit)
// - INT_W   32  output integer width; INT_W >= MAN_W required
// PORTS
// - clk_i        in   1       clock, all state on rising edge
// - rst_n_i      in   1       reset, asynchronous, active-low
// - start_i      in   1       operand valid pulse; op_i sampled same cycle
// - op_i         in   DATA_W  float operand
// - done_o       out  1       result valid pulse, 3 cycles after start_i
// - res_o        out  INT_W   signed integer result
// - overflow_o   out  1       saturation occurred (|value| out of range or +/-Inf)
// - invalid_o    out  1       operand was NaN
// BEHAVIOUR
// - Reset (async, rst_n_i=0): all pipeline registers cleared; done_o=0, res_o=0,
//   overflow_o=0, invalid_o=0. In-flight operands are discarded; no done_o for them after release.
// - Stage 1: register sign, exp, mant={exp!=0, frac}, NaN/Inf decode, valid=start_i.
// - Stage 2: e = exp-BIAS (signed). e<0: mag=0, guard=(e==-1), sticky=(e==-1)? |frac : (exp!=0 | frac!=0).
//   0<=e<=INT_W-1: mag = mant aligned so bit (MAN_W-1) has weight 2^e; shifted-out bits
//   -> guard (MSB dropped) and sticky (OR of rest). e>INT_W-1 or Inf: ovf_pre=1.
// - Stage 3: inc = guard & (sticky | mag[0]) (round-to-nearest-even); magr = mag+inc on INT_W+1 bits.
//   sign=0 & magr > 2**(INT_W-1)-1 -> res=INT_MAX, overflow=1.
//   sign=1 & magr > 2**(INT_W-1)   -> res=INT_MIN, overflow=1.
//   else res = sign ? -magr : magr (exactly -2**(INT_W-1) is legal, overflow=0; -0.0 -> 0).
//   NaN -> res=INT_MAX, invalid=1, overflow=0. Inf -> INT_MAX/INT_MIN by sign, overflow=1.
//   Zero and subnormals -> 0 (subnormal may round to 0 only), flags 0.
// - res_o/overflow_o/invalid_o update only on cycles where done_o=1; hold otherwise.
// - done_o = start_i delayed exactly 3 cycles; back-to-back starts give back-to-back dones, in order.
// - Flags are valid only alongside done_o; both flags never set together.
// CONFIGURATION
// - IOB_FP_F2I_RNE_EN defined: round-to-nearest-even as above.
// - Not defined: truncate toward zero (inc=0, guard/sticky logic removed); latency unchanged;
//   saturation and NaN rules unchanged.
// TESTING
// - start with op_i=0x3FC00000 (1.5) -> done_o 3 cycles later, res_o=2 (RNE) / 1 (trunc).
// - 0x40200000 (2.5) -> 2; 0xC0600000 (-3.5) -> 0xFFFFFFFC (RNE) / 0xFFFFFFFD (trunc).
// - 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow_o=1; 0xCF000000 (-2^31) -> 0x80000000, overflow_o=0.
// - 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid_o=1; 0xFF800000 (-Inf) -> 0x80000000, overflow_o=1.
// - 0x3F000000 (0.5) -> 0; 0x3F400000 (0.75) -> 1 (RNE); 0x00000001 -> 0; 0x80000000 -> 0.
// - 3 consecutive starts, rst_n_i low on 2nd cycle -> done_o/res_o 0 at once, no done after release.

Source files
------------

// File: rtl/iob_fp_f2i.sv
// iob_fp_f2i: pipelined IEEE-754 float to signed two's-complement integer converter.
// Fixed latency of 3 cycles, one operand per cycle, start/done pulse handshake.
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_n_i     asynchronous active-low reset
//   start_i     operand valid pulse, op_i sampled in the same cycle
//   op_i        float operand (sign | exponent | fraction)
//   done_o      result valid pulse, start_i delayed by 3 cycles
//   res_o       signed integer result (held between done pulses)
//   overflow_o  result saturated (|value| out of range or +/-Inf)
//   invalid_o   operand was NaN (result forced to INT_MAX)
//
// Build option:
//   IOB_FP_F2I_RNE_EN  defined: round to nearest, ties to even.
//                      undefined: truncate toward zero.
module iob_fp_f2i #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int INT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] op_i,
  output logic              done_o,
  output logic [INT_W-1:0]  res_o,
  output logic              overflow_o,
  output logic              invalid_o
);

  localparam int MAN_W  = DATA_W - EXP_W;     // includes hidden bit
  localparam int FRAC_W = MAN_W - 1;
  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int WIDE_W = INT_W + MAN_W;
  localparam int E_W    = EXP_W + 2;           // signed unbiased exponent

  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

  // ---------------- stage 1: unpack ----------------
  logic [EXP_W-1:0]  exp_in;
  logic [FRAC_W-1:0] frac_in;

  assign exp_in  = op_i[DATA_W-2 -: EXP_W];
  assign frac_in = op_i[FRAC_W-1:0];

  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [MAN_W-1:0]  s1_mant;
  logic              s1_nan;
  logic              s1_inf;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
    end else begin
      s1_valid <= start_i;
      s1_sign  <= op_i[DATA_W-1];
      s1_exp   <= exp_in;
      s1_mant  <= {|exp_in, frac_in};
      s1_nan   <= (&exp_in) & (|frac_in);
      s1_inf   <= (&exp_in) & ~(|frac_in);
    end
  end

  // ---------------- stage 2: align ----------------
  logic signed [E_W-1:0] e;
  logic [WIDE_W-1:0]     wide;
  logic [INT_W-1:0]      mag_nx;
  logic                  ovf_nx;
`ifdef IOB_FP_F2I_RNE_EN
  logic                  guard_nx;
  logic                  sticky_nx;
`endif

  always_comb begin
    e      = $signed({2'b00, s1_exp}) - $signed(E_W'(BIAS));
    wide   = '0;
    mag_nx = '0;
    ovf_nx = 1'b0;
`ifdef IOB_FP_F2I_RNE_EN
    guard_nx  = 1'b0;
    sticky_nx = 1'b0;
`endif
    if (s1_inf || (e > $signed(E_W'(INT_W-1)))) begin
      ovf_nx = 1'b1;
    end else if (e[E_W-1]) begin
`ifdef IOB_FP_F2I_RNE_EN
      // e == -1 puts the hidden bit in the guard position; below that every
      // set bit (hidden or fraction) only contributes to sticky.
      if (e == '1) begin
        guard_nx  = 1'b1;
        sticky_nx = |s1_mant[FRAC_W-1:0];
      end else begin
        sticky_nx = |s1_mant;
      end
`endif
    end else begin
      // Shift the mantissa up by e, binary point sits FRAC_W bits from the bottom.
      wide   = WIDE_W'(s1_mant) << e[E_W-2:0];
      mag_nx = INT_W'(wide >> FRAC_W);
`ifdef IOB_FP_F2I_RNE_EN
      guard_nx  = wide[FRAC_W-1];
      sticky_nx = |wide[FRAC_W-2:0];
`endif
    end
  end

  logic             s2_valid;
  logic             s2_sign;
  logic             s2_nan;
  logic             s2_ovf;
  logic [INT_W-1:0] s2_mag;
`ifdef IOB_FP_F2I_RNE_EN
  logic             s2_guard;
  logic             s2_sticky;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_mag    <= '0;
`ifdef IOB_FP_F2I_RNE_EN
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
`endif
    end else begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_ovf    <= ovf_nx;
      s2_mag    <= mag_nx;
`ifdef IOB_FP_F2I_RNE_EN
      s2_guard  <= guard_nx;
      s2_sticky <= sticky_nx;
`endif
    end
  end

  // ---------------- stage 3: round, saturate, sign ----------------
  logic             inc;
  logic [INT_W:0]   magr;
  logic [INT_W-1:0] res_nx;
  logic             ovf_res;
  logic             inv_res;

  always_comb begin
`ifdef IOB_FP_F2I_RNE_EN
    inc = s2_guard & (s2_sticky | s2_mag[0]);
`else
    inc = 1'b0;
`endif
    magr    = {1'b0, s2_mag} + (INT_W+1)'(inc);
    res_nx  = '0;
    ovf_res = 1'b0;
    inv_res = 1'b0;
    // NaN also carries an out-of-range exponent, so it must win over overflow.
    if (s2_nan) begin
      res_nx  = INT_MAX;
      inv_res = 1'b1;
    end else if (s2_ovf) begin
      res_nx  = s2_sign ? INT_MIN : INT_MAX;
      ovf_res = 1'b1;
    end else if (!s2_sign && (magr > POS_LIM)) begin
      res_nx  = INT_MAX;
      ovf_res = 1'b1;
    end else if (s2_sign && (magr > NEG_LIM)) begin
      res_nx  = INT_MIN;
      ovf_res = 1'b1;
    end else if (s2_sign) begin
      res_nx  = '0 - magr[INT_W-1:0];
    end else begin
      res_nx  = magr[INT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_o     <= 1'b0;
      res_o      <= '0;
      overflow_o <= 1'b0;
      invalid_o  <= 1'b0;
    end else begin
      done_o <= s2_valid;
      if (s2_valid) begin
        res_o      <= res_nx;
        overflow_o <= ovf_res;
        invalid_o  <= inv_res;
      end
    end
  end

endmodule

// File: tb/tb_iob_fp_f2i.sv
// Bench for iob_fp_f2i (DATA_W=32, EXP_W=8, INT_W=32). Expected results follow
// the build option IOB_FP_F2I_RNE_EN (round-nearest-even) or truncation.
module tb_iob_fp_f2i;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op;
  logic        done;
  logic [31:0] res;
  logic        ovf;
  logic        inv;

  iob_fp_f2i #(.DATA_W(32), .EXP_W(8), .INT_W(32)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .op_i       (op),
    .done_o     (done),
    .res_o      (res),
    .overflow_o (ovf),
    .invalid_o  (inv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] op;
    logic [31:0] r_rne;
    logic [31:0] r_trn;
    logic        ovf;
    logic        inv;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    int          due;
  } exp_t;

  localparam int NV = 30;
  vec_t vecs[NV];
  exp_t sb[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_res = '0;
  logic        last_ovf = 1'b0;
  logic        last_inv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] want_res(input vec_t v);
`ifdef IOB_FP_F2I_RNE_EN
    return v.r_rne;
`else
    return v.r_trn;
`endif
  endfunction

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic issue(input logic [31:0] v, input logic [31:0] r,
                       input logic o, input logic i, input bit push);
    start = 1'b1;
    op    = v;
    if (push) sb.push_back(exp_t'{r, o, i, cyc + 3});
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = $urandom();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard side: pop on every done, otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      last_res = '0;
      last_ovf = 1'b0;
      last_inv = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        cur = sb.pop_front();
        check("latency", 32'(cyc), 32'(cur.due));
        check("res", res, cur.res);
        check("overflow", 32'(ovf), 32'(cur.ovf));
        check("invalid", 32'(inv), 32'(cur.inv));
        last_res = cur.res;
        last_ovf = cur.ovf;
        last_inv = cur.inv;
      end
    end else begin
      check("hold_res", res, last_res);
      check("hold_flags", {30'd0, ovf, inv}, {30'd0, last_ovf, last_inv});
    end
  end

  int nd;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;

    //            op            rne           trunc         ovf   inv
    vecs[0]  = '{32'h3FC00000, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{32'h40200000, 32'h00000002, 32'h00000002, 1'b0, 1'b0};
    vecs[2]  = '{32'hC0600000, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3]  = '{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[4]  = '{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
    vecs[5]  = '{32'h7FC00000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{32'hFF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    vecs[7]  = '{32'h3F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{32'h3F400000, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[11] = '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[12] = '{32'h4F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[13] = '{32'hCF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    vecs[14] = '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 1'b0};
    vecs[15] = '{32'hCEFFFFFF, 32'h80000080, 32'h80000080, 1'b0, 1'b0};
    vecs[16] = '{32'h40600000, 32'h00000004, 32'h00000003, 1'b0, 1'b0};
    vecs[17] = '{32'hBF400000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
    vecs[18] = '{32'h4AFFFFFF, 32'h00800000, 32'h007FFFFF, 1'b0, 1'b0};
    vecs[19] = '{32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[20] = '{32'h42C80000, 32'h00000064, 32'h00000064, 1'b0, 1'b0};
    vecs[21] = '{32'hFFC00001, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[22] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[23] = '{32'h3FE00000, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
    vecs[24] = '{32'hCF000001, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    vecs[25] = '{32'h4B000001, 32'h00800001, 32'h00800001, 1'b0, 1'b0};
    vecs[26] = '{32'h3F7FFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[27] = '{32'hBFC00000, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[28] = '{32'h00800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[29] = '{32'h40400000, 32'h00000003, 32'h00000003, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_res", res, 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_inv", 32'(inv), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass 0 back-to-back, pass 1 with random idle gaps.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NV; i++) begin
        issue(vecs[i].op, want_res(vecs[i]), vecs[i].ovf, vecs[i].inv, 1'b1);
        if (pass == 1) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    drain();

    // Reset in flight: three starts, reset asserted during the second.
    issue(32'h42C80000, 32'h00000064, 1'b0, 1'b0, 1'b1);
    drain();
    issue(32'h3FC00000, 32'h0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    op    = 32'h40200000;
    rst_n = 1'b0;
    #1;
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_res", res, 32'd0);
    check("async_rst_flags", {30'd0, ovf, inv}, 32'd0);
    @(posedge clk);
    #1;
    op = 32'hC0600000;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_reset", 32'(nd), 32'd0);

    // Recovery after reset.
    @(posedge clk);
    #1;
    issue(vecs[2].op, want_res(vecs[2]), vecs[2].ovf, vecs[2].inv, 1'b1);
    issue(vecs[5].op, want_res(vecs[5]), vecs[5].ovf, vecs[5].inv, 1'b1);
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
